// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the 8-bit legacy CPU sequencer:
//   - cpu_state_e : 3-bit CPU state encoding seen by the control unit
//   - FLAG_*      : bit positions inside the flags register
//   - NOP_OPCODE  : instruction register value after reset
//   - needs_imm() : true for opcodes that are followed by an immediate byte
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    INTERRUPT = 3'd5,
    HALT      = 3'd6
  } cpu_state_e;

  // Flags register bit indices.
  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 3;
  localparam int unsigned FLAG_I = 4;

  localparam logic [7:0] NOP_OPCODE = 8'h65;

  // Opcode groups (upper nibble) that carry a one-byte immediate operand.
  localparam logic [3:0] IMM_GROUP_A = 4'h4;
  localparam logic [3:0] IMM_GROUP_B = 4'h5;

  function automatic logic needs_imm(input logic [7:0] opcode);
    return (opcode[7:4] == IMM_GROUP_A) || (opcode[7:4] == IMM_GROUP_B);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// -----------------------------------------------------------------------------
// fetch_timeout_counter
//   Counts consecutive cycles a fetch request waits for its acknowledge.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset
//     clear     : zero the count (takes priority over enable)
//     enable    : count this cycle as a wait cycle
//     limit     : number of wait cycles that constitutes a timeout (>= 1)
//     expired   : high in the wait cycle that makes the count reach limit
// -----------------------------------------------------------------------------
module fetch_timeout_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W:0]   count_next_wide;

  // Extra bit so the comparison cannot wrap at the top of the range.
  assign count_next_wide = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
  assign expired         = enable && !clear && (count_next_wide >= {1'b0, limit});

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_next_wide[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous: it is just the highest-priority branch under the clock edge.
    if (rst) begin
      count_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Instruction sequencer of the 8-bit legacy CPU. Owns the PC, the
//   instruction/operand fetch handshake and interrupt entry, and presents the
//   CPU state plus the latched instruction byte to the control unit.
//   Ports:
//     clk, rst               : clock, synchronous active-high reset
//     mem_req/mem_addr       : fetch request and address (address = pc)
//     mem_rdata/mem_ack      : fetch data and completion (ack ignored w/o req)
//     dmem_done              : datapath data access finished (ends MEMORY)
//     pc_write_en/pc_target  : control-unit PC load, applied in EXECUTE
//     halt_cpu, mem_access   : control-unit decisions taken in EXECUTE
//     irq, irq_en            : level interrupt request and enable flag
//     state                  : current CPU state (cpu_state_e encoding)
//     instruction, operand   : latched opcode and immediate byte
//     pc                     : program counter
//     irq_ack                : high for the single INTERRUPT cycle
//     bus_err                : sticky fetch-timeout flag, cleared only by rst
// -----------------------------------------------------------------------------
module fetch_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_VECTOR  = 8'h00,
  parameter logic [7:0]  IRQ_VECTOR    = 8'hF0,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  input  logic       dmem_done,
  input  logic       pc_write_en,
  input  logic [7:0] pc_target,
  input  logic       halt_cpu,
  input  logic       mem_access,
  input  logic       irq,
  input  logic       irq_en,
  output logic [2:0] state,
  output logic [7:0] instruction,
  output logic [7:0] operand,
  output logic [7:0] pc,
  output logic       irq_ack,
  output logic       bus_err
);

  cpu_state_e state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] instruction_q, instruction_d;
  logic [7:0] operand_q, operand_d;
  logic       mem_req_q, mem_req_d;
  logic       irq_ack_q, irq_ack_d;
  logic       bus_err_q, bus_err_d;

  logic       ack;
  logic       irq_take;
  logic       timeout;

  // An acknowledge only counts while a request is actually outstanding.
  assign ack      = mem_ack && mem_req_q;
  assign irq_take = irq && irq_en;

  // Count restarts whenever no request is outstanding (so every request
  // starts from zero) and on each completed handshake.
  fetch_timeout_counter #(
    .W (8)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!mem_req_q || ack),
    .enable  (mem_req_q && !mem_ack),
    .limit   (8'(FETCH_TIMEOUT)),
    .expired (timeout)
  );

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instruction_d = instruction_q;
    operand_d     = operand_q;
    bus_err_d     = bus_err_q;

    case (state_q)
      FETCH: begin
        if (timeout) begin
          bus_err_d = 1'b1;
          state_d   = HALT;
        end else if (ack) begin
          instruction_d = mem_rdata;
          pc_d          = pc_q + 8'd1;
          state_d       = DECODE;
        end
      end
      DECODE: begin
        if (needs_imm(instruction_q)) begin
          if (timeout) begin
            bus_err_d = 1'b1;
            state_d   = HALT;
          end else if (ack) begin
            operand_d = mem_rdata;
            pc_d      = pc_q + 8'd1;
            state_d   = EXECUTE;
          end
        end else begin
          state_d = EXECUTE;
        end
      end
      EXECUTE: begin
        // A PC load still happens when the same instruction halts.
        if (pc_write_en) begin
          pc_d = pc_target;
        end
        if (halt_cpu) begin
          state_d = HALT;
        end else if (mem_access) begin
          state_d = MEMORY;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        if (dmem_done) begin
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
        state_d = irq_take ? INTERRUPT : FETCH;
      end
      INTERRUPT: begin
        pc_d    = IRQ_VECTOR;
        state_d = FETCH;
      end
      HALT: begin
        if (irq_take) begin
          state_d = INTERRUPT;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state.
    mem_req_d = (state_d == FETCH) ||
                ((state_d == DECODE) && needs_imm(instruction_d));
    irq_ack_d = (state_d == INTERRUPT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      pc_q          <= RESET_VECTOR;
      instruction_q <= NOP_OPCODE;
      operand_q     <= 8'h00;
      mem_req_q     <= 1'b0;
      irq_ack_q     <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instruction_q <= instruction_d;
      operand_q     <= operand_d;
      mem_req_q     <= mem_req_d;
      irq_ack_q     <= irq_ack_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign state       = state_q;
  assign pc          = pc_q;
  assign mem_addr    = pc_q;
  assign mem_req     = mem_req_q;
  assign instruction = instruction_q;
  assign operand     = operand_q;
  assign irq_ack     = irq_ack_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Inputs change 1 time unit after each
//   rising edge and outputs are sampled at the same point, so every check
//   sees the state registered by the preceding edge.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       dmem_done;
  logic       pc_write_en;
  logic [7:0] pc_target;
  logic       halt_cpu;
  logic       mem_access;
  logic       irq;
  logic       irq_en;
  logic [2:0] state;
  logic [7:0] instruction;
  logic [7:0] operand;
  logic [7:0] pc;
  logic       irq_ack;
  logic       bus_err;

  int n_cmp = 0;
  int n_mis = 0;

  localparam logic [7:0] S_FETCH = 8'd0;
  localparam logic [7:0] S_DEC   = 8'd1;
  localparam logic [7:0] S_EXE   = 8'd2;
  localparam logic [7:0] S_MEM   = 8'd3;
  localparam logic [7:0] S_WB    = 8'd4;
  localparam logic [7:0] S_INT   = 8'd5;
  localparam logic [7:0] S_HALT  = 8'd6;

  fetch_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack),
    .dmem_done   (dmem_done),
    .pc_write_en (pc_write_en),
    .pc_target   (pc_target),
    .halt_cpu    (halt_cpu),
    .mem_access  (mem_access),
    .irq         (irq),
    .irq_en      (irq_en),
    .state       (state),
    .instruction (instruction),
    .operand     (operand),
    .pc          (pc),
    .irq_ack     (irq_ack),
    .bus_err     (bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; mem_rdata = 8'h00; mem_ack = 1'b0; dmem_done = 1'b0;
    pc_write_en = 1'b0; pc_target = 8'h00; halt_cpu = 1'b0; mem_access = 1'b0;
    irq = 1'b0; irq_en = 1'b0;

    // Reset values
    step(); step();
    check("rst_state", {5'd0, state}, S_FETCH);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instruction, 8'h65);
    check("rst_operand", operand, 8'h00);
    check("rst_mem_req", {7'd0, mem_req}, 8'd0);
    check("rst_irq_ack", {7'd0, irq_ack}, 8'd0);
    check("rst_bus_err", {7'd0, bus_err}, 8'd0);

    // Zero-wait fetch of 8'h00: FETCH, DECODE, EXECUTE, WRITEBACK, FETCH
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h00;
    step();
    check("t1_req_state", {5'd0, state}, S_FETCH);
    check("t1_req", {7'd0, mem_req}, 8'd1);
    check("t1_addr", mem_addr, 8'h00);
    step();
    check("t1_decode", {5'd0, state}, S_DEC);
    check("t1_pc", pc, 8'h01);
    check("t1_instr", instruction, 8'h00);
    check("t1_noreq", {7'd0, mem_req}, 8'd0);
    mem_ack = 1'b0;
    step();
    check("t1_execute", {5'd0, state}, S_EXE);
    step();
    check("t1_wb", {5'd0, state}, S_WB);
    step();
    check("t1_fetch", {5'd0, state}, S_FETCH);
    check("t1_addr2", mem_addr, 8'h01);

    // 8'h50 + operand 8'h20, two wait cycles each, then PC load
    step(); step();
    check("t2_wait_fetch", {5'd0, state}, S_FETCH);
    mem_ack = 1'b1; mem_rdata = 8'h50;
    step();
    check("t2_decode", {5'd0, state}, S_DEC);
    check("t2_instr", instruction, 8'h50);
    check("t2_pc", pc, 8'h02);
    check("t2_imm_req", {7'd0, mem_req}, 8'd1);
    mem_ack = 1'b0;
    step(); step();
    check("t2_wait_dec", {5'd0, state}, S_DEC);
    mem_ack = 1'b1; mem_rdata = 8'h20;
    step();
    check("t2_execute", {5'd0, state}, S_EXE);
    check("t2_operand", operand, 8'h20);
    check("t2_pc_imm", pc, 8'h03);
    mem_ack = 1'b0; pc_write_en = 1'b1; pc_target = 8'h20;
    step();
    check("t2_wb", {5'd0, state}, S_WB);
    check("t2_pc_load", pc, 8'h20);
    pc_write_en = 1'b0;
    step();
    check("t2_fetch", {5'd0, state}, S_FETCH);

    // PC wrap: non-imm at FF, imm opcode at FE
    mem_ack = 1'b1; mem_rdata = 8'h00;
    step();
    mem_ack = 1'b0;
    step();
    pc_write_en = 1'b1; pc_target = 8'hFF;
    step();
    pc_write_en = 1'b0;
    step();
    check("t3_addr_ff", mem_addr, 8'hFF);
    mem_ack = 1'b1;
    step();
    check("t3_wrap", pc, 8'h00);
    mem_ack = 1'b0;
    step();
    pc_write_en = 1'b1; pc_target = 8'hFE;
    step();
    pc_write_en = 1'b0;
    step();
    mem_ack = 1'b1; mem_rdata = 8'h40;
    step();
    check("t3_imm_pc", pc, 8'hFF);
    check("t3_imm_instr", instruction, 8'h40);
    mem_rdata = 8'h77;
    step();
    check("t3_wrap_imm", pc, 8'h00);
    check("t3_operand", operand, 8'h77);
    mem_ack = 1'b0;

    // MEMORY held three cycles until dmem_done
    mem_access = 1'b1;
    step();
    check("t4_mem1", {5'd0, state}, S_MEM);
    check("t4_mem_noreq", {7'd0, mem_req}, 8'd0);
    mem_access = 1'b0;
    step();
    check("t4_mem2", {5'd0, state}, S_MEM);
    step();
    check("t4_mem3", {5'd0, state}, S_MEM);
    dmem_done = 1'b1;
    step();
    check("t4_wb", {5'd0, state}, S_WB);
    check("t4_operand_hold", operand, 8'h77);
    check("t4_instr_hold", instruction, 8'h40);
    dmem_done = 1'b0;
    step();

    // Interrupt raised in EXECUTE, taken at WRITEBACK
    mem_ack = 1'b1; mem_rdata = 8'h00;
    step();
    mem_ack = 1'b0;
    step();
    check("t5_execute", {5'd0, state}, S_EXE);
    irq = 1'b1; irq_en = 1'b1;
    step();
    check("t5_wb", {5'd0, state}, S_WB);
    check("t5_noack_wb", {7'd0, irq_ack}, 8'd0);
    step();
    check("t5_int", {5'd0, state}, S_INT);
    check("t5_irq_ack", {7'd0, irq_ack}, 8'd1);
    step();
    check("t5_fetch", {5'd0, state}, S_FETCH);
    check("t5_vector", pc, 8'hF0);
    check("t5_ack_pulse", {7'd0, irq_ack}, 8'd0);
    irq_en = 1'b0; mem_ack = 1'b1;
    step();
    check("t5_fetch_irq_ignored", {5'd0, state}, S_DEC);
    mem_ack = 1'b0;
    step(); step(); step();
    check("t5_masked", {5'd0, state}, S_FETCH);
    check("t5_masked_pc", pc, 8'hF1);
    irq = 1'b0;

    // Halt with PC load in the same EXECUTE, then interrupt out of HALT
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    halt_cpu = 1'b1; pc_write_en = 1'b1; pc_target = 8'h33;
    step();
    check("t6_halt", {5'd0, state}, S_HALT);
    check("t6_halt_pc", pc, 8'h33);
    check("t6_halt_noreq", {7'd0, mem_req}, 8'd0);
    halt_cpu = 1'b0; pc_write_en = 1'b0; mem_ack = 1'b1;
    step(); step();
    check("t6_halt_stay", {5'd0, state}, S_HALT);
    check("t6_pc_frozen", pc, 8'h33);
    mem_ack = 1'b0; irq = 1'b1; irq_en = 1'b1;
    step();
    check("t6_halt_int", {5'd0, state}, S_INT);
    irq = 1'b0;
    step();
    check("t6_vector", pc, 8'hF0);

    // Fetch timeout from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("t7_req", {7'd0, mem_req}, 8'd1);
    repeat (14) step();
    check("t7_before_to", {7'd0, bus_err}, 8'd0);
    check("t7_before_state", {5'd0, state}, S_FETCH);
    step();
    check("t7_bus_err", {7'd0, bus_err}, 8'd1);
    check("t7_halt", {5'd0, state}, S_HALT);
    check("t7_req_drop", {7'd0, mem_req}, 8'd0);
    check("t7_instr", instruction, 8'h65);
    irq = 1'b1; irq_en = 1'b1;
    step();
    check("t7_int", {5'd0, state}, S_INT);
    irq = 1'b0;
    step();
    check("t7_sticky", {7'd0, bus_err}, 8'd1);
    check("t7_refetch", {7'd0, mem_req}, 8'd1);
    rst = 1'b1;
    step();
    check("t7_rst_clear", {7'd0, bus_err}, 8'd0);
    check("t7_rst_req", {7'd0, mem_req}, 8'd0);
    check("t7_rst_state", {5'd0, state}, S_FETCH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
